// File: rtl/hamming_serial_rx.sv
// rtl/hamming_serial_rx.sv - 8N1-style serial receiver for 7-bit Hamming codewords
// Optional input synchronizer: define HAMMING_RX_SYNC_EN.
module hamming_serial_rx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [6:0] code_out,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {BREAK, IDLE, START, DATA, STOP} state_t;

    state_t        state, nextState;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    idx, idxNext;
    logic [6:0]    shiftReg, shiftNext;
    logic [6:0]    codeNext;
    logic          validNext, errNext;
    logic          rxIn;

`ifdef HAMMING_RX_SYNC_EN
    logic [1:0] rxSync;

    // Resets to the idle level so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxSync <= 2'b11;
        else        rxSync <= {rxSync[0], rx};
    end
    assign rxIn = rxSync[1];
`else
    assign rxIn = rx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BREAK;
            cnt        <= '0;
            idx        <= '0;
            shiftReg   <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= nextState;
            cnt        <= cntNext;
            idx        <= idxNext;
            shiftReg   <= shiftNext;
            code_out   <= codeNext;
            code_valid <= validNext;
            frame_err  <= errNext;
        end
    end

    always_comb begin
        nextState = state;
        cntNext   = cnt + 1'b1;
        idxNext   = idx;
        shiftNext = shiftReg;
        codeNext  = code_out;
        validNext = 1'b0;
        errNext   = 1'b0;
        case (state)
            BREAK: begin
                cntNext = '0;
                if (rxIn) nextState = IDLE;
            end
            IDLE: begin
                cntNext = '0;
                if (!rxIn) nextState = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cntNext = '0;
                    if (rxIn) begin
                        nextState = IDLE;
                    end else begin
                        nextState = DATA;
                        idxNext   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cntNext        = '0;
                    shiftNext[idx] = rxIn;
                    idxNext        = idx + 3'd1;
                    if (idx == 3'd6) nextState = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cntNext = '0;
                    if (rxIn) begin
                        codeNext  = shiftReg;
                        validNext = 1'b1;
                        nextState = IDLE;
                    end else begin
                        errNext   = 1'b1;
                        nextState = BREAK;
                    end
                end
            end
            default: nextState = BREAK;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Serial front-end for the Hamming 7,4 decode path. It deserializes 7-bit codewords from a single asynchronous serial line, using a start bit, seven data bits sent LSB first, and one stop bit. Each received codeword is presented as a registered 7-bit word with a one-cycle valid strobe. The block sits directly upstream of the codeword selector/detector in `top`, and its `code_out` drives the `dataRaw` input of the detection/correction stages.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit. Must be even and ≥ 4; other values are unsupported.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx`  in  1  serial line. It idles high. A frame is 1 start bit (0), then d0..d6, then 1 stop bit (1).
- `code_out`  out  7  last good codeword; bit i is the i-th data bit received. Holds its value between frames.
- `code_valid`  out  1  one-cycle pulse when `code_out` has just been updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has five states: BREAK, IDLE, START, DATA, STOP. The block contains a bit-period counter `cnt` (log2(CLK_DIV) bits) and a bit index `idx` (3 bits).
- **BREAK**: entered on reset and after a framing error. Moves to IDLE on the first cycle `rx`=1. This ensures a line held low at reset release never yields a frame.
- **IDLE**: when `rx`=0, go to START and clear `cnt`.
- **START**: count CLK_DIV/2 cycles to reach the middle of the start bit, then sample.
  - If `rx`=1 (glitch), return to IDLE with no output.
  - If `rx`=0, go to DATA with `idx`=0 and `cnt` cleared.
- **DATA**: every CLK_DIV cycles, sample `rx` into shift-register bit `idx`, then increment `idx`. After the sample taken at `idx`=6, go to STOP.
- **STOP**: after CLK_DIV cycles, sample `rx`.
  - If `rx`=1: load `code_out` from the shift register, pulse `code_valid`, and go to IDLE.
  - If `rx`=0: pulse `frame_err`, leave `code_out` unchanged, and go to BREAK.
- `code_valid` and `frame_err` are mutually exclusive; they are never high in the same cycle.
- The counter wraps to 0 at CLK_DIV−1 in DATA and STOP, and at CLK_DIV/2−1 in START. No other arithmetic is performed.
- Asserting reset in the middle of a frame aborts it immediately:
  - no `code_valid` or `frame_err` is produced for that frame;
  - the partial shift-register contents are discarded;
  - the FSM restarts in BREAK.

## Timing
- Reset values: `code_out`=7'h00, `code_valid`=0, `frame_err`=0, `busy`=1 (state BREAK). The shift register, `cnt` and `idx` are also 0.
- Define t0 as the rising edge at which IDLE first sees `rx`=0.
  - Start-bit sample: edge t0 + CLK_DIV/2.
  - Data bit k sample: edge t0 + CLK_DIV/2 + (k+1)·CLK_DIV.
  - Stop-bit sample: edge t0 + CLK_DIV/2 + 8·CLK_DIV.
- `code_out` and `code_valid` (or `frame_err`) change on the stop-sample edge. They are visible for exactly one cycle after it.
- Frames may be back-to-back. The FSM returns to IDLE at the stop-sample edge, so a start bit that begins half a bit later is accepted.
- Transmitter bit-rate tolerance is ±4% of nominal.

## Configuration
- Macro: `HAMMING_RX_SYNC_EN`.
- **Defined**: `rx` passes through a two-flop synchronizer, reset to 1, before the FSM. All timing in the Timing section shifts by +2 cycles relative to the pin.
- **Undefined**: `rx` feeds the FSM directly, and the source must already be synchronous to `clk`. No other behaviour changes.

## Test plan
All scenarios use CLK_DIV=16 with `HAMMING_RX_SYNC_EN` undefined.
- **Good frame**: send codeword 7'h33 (bits 1,1,0,0,1,1,0) with stop bit 1 → `code_out`=7'h33 and a single `code_valid` pulse at edge t0+136. `frame_err` stays 0.
- **Start glitch**: hold `rx` low for 4 cycles, then high → FSM returns to IDLE at t0+8. No `code_valid`, no `frame_err`, and `code_out` is unchanged.
- **Framing error**: send 7'h55 with stop bit 0 → `frame_err` pulses at t0+136 and `code_out` keeps its prior value 7'h33. The FSM stays busy in BREAK until `rx` returns high, and a frame starting while `rx` is still low is ignored.
- **Back-to-back frames**: send 7'h7F immediately followed by 7'h00 → two `code_valid` pulses 144 cycles apart, with `code_out` reading 7'h7F then 7'h00.
- **Reset mid-frame**: assert `rst_n`=0 at t0+60 while sending 7'h2A → all outputs return to their reset values immediately. No `code_valid` follows, and the next clean frame 7'h2A is received correctly.
- **Low at reset release**: hold `rx`=0 through reset deassertion for 200 cycles, then drive it high → no `code_valid`/`frame_err`, and `busy` stays 1 until `rx` goes high.
